// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
// Requester 0 is ALU writeback, requester 1 is load return.
package regfile_arb_pkg;
  localparam int RF_W  = 16;
  localparam int RF_A  = 4;
  localparam int RF_CW = 8;

  typedef enum logic {REQ_ALU = 1'b0, REQ_LOAD = 1'b1} req_id_t;

  typedef struct packed {
    logic [RF_A-1:0] addr;
    logic [RF_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. prio names the port that wins a tie and
// flips to the other port after every grant that is taken.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  req_id_t prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (prio == REQ_LOAD) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i)     prio <= REQ_ALU;
    else if (advance) prio <= gnt[REQ_ALU] ? REQ_LOAD : REQ_ALU;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU writeback and load return.
// The winner is staged one cycle; both read ports forward from the staged write.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int W  = RF_W,
  parameter int A  = RF_A,
  parameter int CW = RF_CW
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic [1:0]    req_valid_i,
  input  logic [A-1:0]  req_addr0_i,
  input  logic [A-1:0]  req_addr1_i,
  input  logic [W-1:0]  req_data0_i,
  input  logic [W-1:0]  req_data1_i,
  output logic [1:0]    req_ready_o,
  output logic          wen_o,
  output logic [A-1:0]  wa_o,
  output logic [W-1:0]  wd_o,
  input  logic [A-1:0]  ra0_i,
  input  logic [A-1:0]  ra1_i,
  input  logic [W-1:0]  rf_rd0_i,
  input  logic [W-1:0]  rf_rd1_i,
  output logic [W-1:0]  rd0_o,
  output logic [W-1:0]  rd1_o,
  output logic [CW-1:0] conflict_cnt_o
);
  localparam int NUM_RD = 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } stage_t;

  logic [1:0]   gnt;
  logic         xfer;
  stage_t [1:0] req;
  stage_t       win, stg;

  // Ready is the grant itself; the register file never stalls, so any grant transfers.
  assign xfer        = |(req_valid_i & gnt);
  assign req_ready_o = gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n_i (rst_n_i),
    .req     (req_valid_i),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign req[REQ_ALU]  = '{addr: req_addr0_i, data: req_data0_i};
  assign req[REQ_LOAD] = '{addr: req_addr1_i, data: req_data1_i};
  assign win           = gnt[REQ_LOAD] ? req[REQ_LOAD] : req[REQ_ALU];

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wen_o <= 1'b0;
      stg   <= '0;
    end else begin
      wen_o <= xfer;
      if (xfer) stg <= win;
    end
  end

  assign wa_o = stg.addr;
  assign wd_o = stg.data;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i)
      conflict_cnt_o <= '0;
    else if (&req_valid_i && conflict_cnt_o != CNT_MAX)
      conflict_cnt_o <= conflict_cnt_o + CW'(1);
  end

  logic [NUM_RD-1:0][A-1:0] ra;
  logic [NUM_RD-1:0][W-1:0] rf_rd, rd;

  assign ra    = {ra1_i, ra0_i};
  assign rf_rd = {rf_rd1_i, rf_rd0_i};

  // The staged write commits at the next edge, so the array still holds old data.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_fwd
    assign rd[p] = (wen_o && wa_o == ra[p]) ? wd_o : rf_rd[p];
  end

  assign rd0_o = rd[0];
  assign rd1_o = rd[1];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: the stimulus side predicts grants and queues expected
// writes; a monitor pops them each cycle and checks write port, forwarding and counter.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [1:0]  req_valid_i;
  logic [3:0]  req_addr0_i, req_addr1_i;
  logic [15:0] req_data0_i, req_data1_i;
  logic [1:0]  req_ready_o;
  logic        wen_o;
  logic [3:0]  wa_o;
  logic [15:0] wd_o;
  logic [3:0]  ra0_i, ra1_i;
  logic [15:0] rf_rd0_i, rf_rd1_i;
  logic [15:0] rd0_o, rd1_o;
  logic [7:0]  conflict_cnt_o;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i),
    .req_addr0_i(req_addr0_i), .req_addr1_i(req_addr1_i),
    .req_data0_i(req_data0_i), .req_data1_i(req_data1_i),
    .req_ready_o(req_ready_o), .wen_o(wen_o), .wa_o(wa_o), .wd_o(wd_o),
    .ra0_i(ra0_i), .ra1_i(ra1_i), .rf_rd0_i(rf_rd0_i), .rf_rd1_i(rf_rd1_i),
    .rd0_o(rd0_o), .rd1_o(rd1_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] a; logic [15:0] d; } wr_t;

  wr_t         exp_q[$];
  int          errors = 0, checks = 0;
  int          mprio = 0, mcnt = 0;
  logic [3:0]  last_a = '0;
  logic [15:0] last_d = '0;
  bit          pv[2];
  logic [3:0]  pa[2];
  logic [15:0] pd[2];
  logic [3:0]  ra_v[2];
  logic [15:0] rf_v[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    mprio = 0; mcnt = 0; last_a = '0; last_d = '0;
    pv[0] = 0; pv[1] = 0;
  endtask

  // One bus cycle: drive pending requests, check ready, predict the outcome.
  task automatic step();
    int g;
    logic [1:0] er;
    @(negedge clk);
    req_valid_i = {pv[1], pv[0]};
    req_addr0_i = pa[0]; req_data0_i = pd[0];
    req_addr1_i = pa[1]; req_data1_i = pd[1];
    ra0_i = ra_v[0]; ra1_i = ra_v[1];
    rf_rd0_i = rf_v[0]; rf_rd1_i = rf_v[1];
    #1;
    if (pv[0] && pv[1]) g = mprio;
    else if (pv[0])     g = 0;
    else if (pv[1])     g = 1;
    else                g = -1;
    er = (g < 0) ? 2'b00 : (2'b01 << g);
    chk("ready", {30'd0, req_ready_o}, {30'd0, er});
    if (pv[0] && pv[1] && mcnt < 255) mcnt++;
    if (g >= 0) begin
      exp_q.push_back('{a: pa[g], d: pd[g]});
      mprio = 1 - g;
      pv[g] = 0;
    end
  endtask

  task automatic post(input int k, input logic [3:0] a, input logic [15:0] d);
    pv[k] = 1; pa[k] = a; pd[k] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n_i = 1'b0;
    req_valid_i = 2'b00;
    model_clear();
    #1;
    chk("rst_wen", {31'd0, wen_o}, 32'd0);
    chk("rst_wa",  {28'd0, wa_o}, 32'd0);
    chk("rst_wd",  {16'd0, wd_o}, 32'd0);
    chk("rst_cnt", {24'd0, conflict_cnt_o}, 32'd0);
    chk("rst_rdy", {30'd0, req_ready_o}, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  // Monitor: sample shortly after each rising edge.
  initial begin
    wr_t e;
    logic [15:0] x0, x1;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_a = e.a; last_d = e.d;
        chk("wen", {31'd0, wen_o}, 32'd1);
        x0 = (e.a == ra0_i) ? e.d : rf_rd0_i;
        x1 = (e.a == ra1_i) ? e.d : rf_rd1_i;
      end else begin
        chk("wen_idle", {31'd0, wen_o}, 32'd0);
        x0 = rf_rd0_i;
        x1 = rf_rd1_i;
      end
      chk("wa",  {28'd0, wa_o}, {28'd0, last_a});
      chk("wd",  {16'd0, wd_o}, {16'd0, last_d});
      chk("rd0", {16'd0, rd0_o}, {16'd0, x0});
      chk("rd1", {16'd0, rd1_o}, {16'd0, x1});
      chk("cnt", {24'd0, conflict_cnt_o}, mcnt);
    end
  end

  initial begin
    rst_n_i = 1'b0;
    req_valid_i = 2'b00;
    req_addr0_i = '0; req_addr1_i = '0; req_data0_i = '0; req_data1_i = '0;
    ra0_i = '0; ra1_i = '0; rf_rd0_i = '0; rf_rd1_i = '0;
    for (int k = 0; k < 2; k++) begin
      pa[k] = '0; pd[k] = '0; ra_v[k] = 4'hF; rf_v[k] = 16'hC0DE;
    end
    model_clear();
    do_reset();

    // Single request, then idle.
    post(0, 4'd3, 16'h00AA);
    step(); step(); step();

    // Two-way contention from reset: port 0 first, then port 1.
    do_reset();
    post(0, 4'd1, 16'h0010);
    post(1, 4'd2, 16'h0020);
    repeat (4) step();

    // Sustained contention: refill both ports every cycle.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (!pv[0]) post(0, 4'(c), 16'(16'h0100 + c));
      if (!pv[1]) post(1, 4'(c + 8), 16'(16'h0200 + c));
      step();
    end
    pv[0] = 0; pv[1] = 0;
    step();

    // Forwarding on both read ports, then a miss on port 0.
    ra_v[0] = 4'd5; ra_v[1] = 4'd5; rf_v[0] = 16'h0; rf_v[1] = 16'h0;
    post(0, 4'd5, 16'h1234);
    step();
    ra_v[0] = 4'd6; rf_v[0] = 16'h5555;
    post(1, 4'd5, 16'h4321);
    step();
    step();

    // Counter saturation.
    for (int c = 0; c < 300; c++) begin
      if (!pv[0]) post(0, 4'($urandom_range(0, 15)), 16'($urandom));
      if (!pv[1]) post(1, 4'($urandom_range(0, 15)), 16'($urandom));
      step();
    end
    chk("sat", {24'd0, conflict_cnt_o}, 32'd255);
    pv[0] = 0; pv[1] = 0;
    step();

    // Random traffic with a small address space so forwarding hits often.
    do_reset();
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pv[k] && $urandom_range(0, 2) != 0)
          post(k, 4'($urandom_range(0, 3)), 16'($urandom));
        ra_v[k] = 4'($urandom_range(0, 3));
        rf_v[k] = 16'($urandom);
      end
      step();
    end
    pv[0] = 0; pv[1] = 0;
    step();

    // Reset while a staged write is on the port.
    post(0, 4'd7, 16'hBEEF);
    post(1, 4'd9, 16'h0999);
    step();
    @(posedge clk);
    #3;
    chk("mid_wen_pre", {31'd0, wen_o}, 32'd1);
    rst_n_i = 1'b0;
    req_valid_i = 2'b00;
    model_clear();
    #1;
    chk("mid_wen", {31'd0, wen_o}, 32'd0);
    chk("mid_cnt", {24'd0, conflict_cnt_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
    // Priority must be back at port 0.
    post(0, 4'd7, 16'hBEEF);
    post(1, 4'd9, 16'h0999);
    repeat (3) step();

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 16-entry `register` file between two requesters (requester 0 = ALU writeback, requester 1 = load return) using round-robin arbitration with a valid/ready handshake. The winning write is staged one cycle and then driven onto the register file write port. Both read ports are forwarded from that staged write so consumers never see stale data.

## Interface
Parameters:
- W, 16, data width
- A, 4, register address width (2^A registers)
- CW, 8, width of the saturating conflict counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  2  per-requester write request valid
- req_addr0_i / req_addr1_i  in  A  write address of requester 0 / 1
- req_data0_i / req_data1_i  in  W  write data of requester 0 / 1
- req_ready_o  out  2  per-requester accept; combinational, one-hot or zero
- wen_o  out  1  register file write enable (to `wen_i`)
- wa_o  out  A  register file write address (to `wa_i`)
- wd_o  out  W  register file write data (to `wd_i`)
- ra0_i / ra1_i  in  A  consumer read addresses; passed through to register file `ra0_i` / `ra1_i`
- rf_rd0_i / rf_rd1_i  in  W  raw register file read data
- rd0_o / rd1_o  out  W  forwarded read data to consumers
- conflict_cnt_o  out  CW  saturating count of cycles with both requesters valid

## Operation
- Handshake: a transfer on port k occurs when `req_valid_i[k] && req_ready_o[k]` at a rising edge. Once valid is high, the requester holds valid, address and data stable until accepted.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: the port indicated by priority pointer `prio` is granted.
  - None valid: `req_ready_o = 2'b00`.
  - The arbiter grants every cycle; the register file never back-pressures.
- Priority pointer: a 1-bit register. After a transfer on port k, `prio <= ~k`. With no transfer, `prio` holds. Reset value is 0.
- Write stage: an accepted request loads `wa_o`/`wd_o` and sets `wen_o=1` for exactly the following cycle. With no transfer, `wen_o` goes to 0 and `wa_o`/`wd_o` hold.
- Forwarding:
  - `rd0_o = (wen_o && wa_o==ra0_i) ? wd_o : rf_rd0_i`; `rd1_o` is identical using port 1.
  - Both read ports may forward simultaneously.
- Conflict counter: increments on every cycle with `req_valid_i==2'b11`, saturates at 2^CW−1, never wraps, and clears only on reset.
- Same-address requests from both ports are not merged. They are committed in grant order, so the later grant wins in the register file.

## Timing
- Reset values (asserted asynchronously): `wen_o=0`, `wa_o=0`, `wd_o=0`, `prio=0`, `conflict_cnt_o=0`. `req_ready_o` and `rd*_o` are combinational and follow their inputs.
- Latency:
  - Accept at edge N.
  - `wen_o` is high during cycle N→N+1.
  - The register file commits at edge N+1.
  - Forwarded data is visible combinationally during cycle N→N+1.
- Throughput: one write per cycle total. Under continuous contention the ports alternate 0,1,0,1,… starting from the current `prio`.
- Reset mid-operation: a write accepted at edge N and staged when `rst_n_i` falls is dropped (`wen_o` forced to 0 immediately). Requesters re-present after reset.
- `req_ready_o` depends only on `req_valid_i` and `prio`, never on the data/address inputs. There is no combinational path from ready to valid.

## Structure
- Package `regfile_arb_pkg`:
  - default W/A/CW localparams
  - `typedef enum logic {REQ_ALU=1'b0, REQ_LOAD=1'b1} req_id_t`
  - `typedef struct packed {logic [A-1:0] addr; logic [W-1:0] data;} wr_req_t`
- Sub-module `rr_arb2`: 2-way round-robin arbiter owning `prio`.
  - Inputs: clk, rst_n_i, req[1:0], advance.
  - Output: gnt[1:0] (one-hot or zero).
- The top level holds the write stage register, the forwarding muxes and the conflict counter.

## Test plan
- Reset then single request: `req_valid_i=01`, addr 3, data 16'h00AA.
  - Expect `req_ready_o=01` that cycle.
  - Next cycle `wen_o=1, wa_o=3, wd_o=00AA`.
  - Cycle after, `wen_o=0`.
- Contention, 4 cycles: both valid, port0 addr 1/data 10, port1 addr 2/data 20, each dropping valid after its accept.
  - Grants: 0 then 1.
  - Writes: (1,10) then (2,20).
  - `conflict_cnt_o=1`.
- Sustained contention, 6 cycles, both always valid: grants alternate 0,1,0,1,0,1; `conflict_cnt_o=6`.
- Forwarding: write addr 5 data 16'h1234 with `ra0_i=ra1_i=5` and `rf_rd*_i=0`.
  - `rd0_o=rd1_o=1234` while `wen_o=1`.
  - With `ra0_i=6` during the same cycle, `rd0_o` equals `rf_rd0_i`.
- Saturation: with CW=8, hold both valid for 300 cycles; `conflict_cnt_o` stops at 255.
- Reset mid-operation: accept a write (addr 7, data 16'hBEEF), then deassert `rst_n_i` mid-cycle while `wen_o=1`.
  - `wen_o` drops immediately.
  - `prio=0` and counter=0 after release.
